// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Holds the FSM encoding and the serial word framing.
package inst_loader_pkg;

   localparam int BYTES_PER_WORD = 3;
   localparam int WORD_W         = 19;
   localparam int BCNT_W         = 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR    = 3'd1,
      S_DATA   = 3'd2,
      S_WRITE  = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   // A final byte may only carry the 3 top bits of a word.
   function automatic logic top_byte_bad(input logic [7:0] b);
      return |b[7:3];
   endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write bus.
// master is the loader side, slave the stream source / memory.
interface inst_loader_if #(
   parameter int AW = 19,
   parameter int DW = 19
);

   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata;

   modport master (
      input  byte_in,
      input  byte_valid,
      output byte_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      output byte_in,
      output byte_valid,
      input  byte_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );

endinterface

// File: rtl/inst_loader_byte_assembler.sv
// Builds a 19-bit little-endian word from 3 serial bytes.
// word shows the value including a byte taken this cycle.
module byte_assembler
   import inst_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              take,
   input  logic [7:0]        byte_in,
   output logic              last,
   output logic              fmt_bad,
   output logic [WORD_W-1:0] word
);

   logic [WORD_W-1:0] word_q, word_d;
   logic [BCNT_W-1:0] cnt_q, cnt_d;

   assign last    = take && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
   assign fmt_bad = last && top_byte_bad(byte_in);
   assign word    = word_d;

   // Place each accepted byte into its slot and advance the count.
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clr) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (take) begin
         unique case (cnt_q)
            2'd0:    word_d[7:0]   = byte_in;
            2'd1:    word_d[15:8]  = byte_in;
            default: word_d[18:16] = byte_in[2:0];
         endcase
         cnt_d = last ? '0 : cnt_q + 2'd1;
      end
   end

   // Assembly register and byte counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/inst_loader.sv
// Serial instruction loader: header word count, then N words
// written to instruction memory while the CPU is held.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int AW = 19,
   parameter int DW = 19
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   inst_loader_if.master bus,
   output logic         cpu_hold,
   output logic         pc_clear,
   output logic         busy,
   output logic         done,
   output logic         fmt_err
);

   state_t            state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [WORD_W-1:0] wcnt_q, wcnt_d;
   logic              fmt_q, fmt_d;

   logic              sess_start;
   logic              xfer;
   logic              hdr_take, hdr_last, hdr_bad;
   logic              dat_take, dat_last, dat_bad;
   logic [WORD_W-1:0] n_words;
   logic [WORD_W-1:0] dat_word;

   assign sess_start = (state_q == S_IDLE) && start;
   assign xfer       = bus.byte_valid && bus.byte_ready;
   assign hdr_take   = xfer && (state_q == S_HDR);
   assign dat_take   = xfer && (state_q == S_DATA);

   byte_assembler u_hdr (
      .clk     (clk),
      .rst     (rst),
      .clr     (sess_start),
      .take    (hdr_take),
      .byte_in (bus.byte_in),
      .last    (hdr_last),
      .fmt_bad (hdr_bad),
      .word    (n_words)
   );

   byte_assembler u_dat (
      .clk     (clk),
      .rst     (rst),
      .clr     (sess_start),
      .take    (dat_take),
      .byte_in (bus.byte_in),
      .last    (dat_last),
      .fmt_bad (dat_bad),
      .word    (dat_word)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_HDR;
         end
         S_HDR: begin
            if (hdr_last) begin
               state_d = (n_words == '0) ? S_FINISH : S_DATA;
            end
         end
         S_DATA: begin
            if (dat_last) state_d = S_WRITE;
         end
         S_WRITE: begin
            if ((wcnt_q + WORD_W'(1)) == n_words) begin
               state_d = S_FINISH;
            end else begin
               state_d = S_DATA;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Address, written-word count and sticky format error.
   always_comb begin
      addr_d = addr_q;
      wcnt_d = wcnt_q;
      fmt_d  = fmt_q | hdr_bad | dat_bad;
      if (sess_start) begin
         addr_d = '0;
         wcnt_d = '0;
         fmt_d  = 1'b0;
      end else if (state_q == S_WRITE) begin
         addr_d = addr_q + AW'(1);
         wcnt_d = wcnt_q + WORD_W'(1);
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         wcnt_q <= '0;
         fmt_q  <= 1'b0;
      end else begin
         addr_q <= addr_d;
         wcnt_q <= wcnt_d;
         fmt_q  <= fmt_d;
      end
   end

   // Outputs decoded from the current state; bus idles at zero.
   always_comb begin
      bus.byte_ready = 1'b0;
      bus.imem_we    = 1'b0;
      bus.imem_addr  = '0;
      bus.imem_wdata = '0;
      busy           = (state_q != S_IDLE);
      cpu_hold       = (state_q != S_IDLE);
      pc_clear       = 1'b0;
      done           = 1'b0;
      fmt_err        = fmt_q;
      unique case (state_q)
         S_HDR, S_DATA: begin
            bus.byte_ready = 1'b1;
         end
         S_WRITE: begin
            bus.imem_we    = 1'b1;
            bus.imem_addr  = addr_q;
            bus.imem_wdata = DW'(dat_word);
         end
         S_FINISH: begin
            pc_clear = 1'b1;
            done     = 1'b1;
         end
         default: begin
            bus.byte_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_inst_loader.sv
// Randomised bench for inst_loader with a transaction-level model
// of the session byte stream and a per-cycle output compare.
module tb_inst_loader;

   localparam int AW = 4;
   localparam int DW = 19;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic cpu_hold, pc_clear, busy, done, fmt_err;

   inst_loader_if #(.AW(AW), .DW(DW)) bus ();

   inst_loader #(.AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .pc_clear (pc_clear),
      .busy     (busy),
      .done     (done),
      .fmt_err  (fmt_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;
   int n_wr = 0;
   int n_done = 0;
   logic [18:0] tb_mem [16];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Session model: counts accepted bytes, frames words, and
   // predicts what the outputs must be during the next cycle.
   bit          m_act, m_hdr_done;
   int          m_nb, m_n, m_wr;
   logic [7:0]  m_b [3];
   logic [18:0] m_word;
   bit          e_we, e_done, e_ready, e_busy, e_fmt;
   logic [AW-1:0] e_addr;
   logic [18:0] e_data;

   always @(posedge clk) begin
      bit xfer, nwe, ndone;
      xfer  = bus.byte_valid && e_ready;
      nwe   = 0;
      ndone = 0;
      if (rst) begin
         m_act = 0;
         e_fmt = 0;
      end else if (e_done) begin
         m_act = 0;
      end else if (!m_act) begin
         if (start) begin
            m_act = 1; m_hdr_done = 0;
            m_nb = 0; m_wr = 0; e_fmt = 0;
         end
      end else if (e_we) begin
         m_wr++;
         if (m_wr == m_n) ndone = 1;
      end else if (xfer) begin
         m_b[m_nb] = bus.byte_in;
         m_nb++;
         if (m_nb == 3) begin
            m_nb = 0;
            if (m_b[2] > 8'd7) e_fmt = 1;
            m_word = {m_b[2][2:0], m_b[1], m_b[0]};
            if (!m_hdr_done) begin
               m_hdr_done = 1;
               m_n = int'(m_word);
               if (m_n == 0) ndone = 1;
            end else begin
               nwe = 1;
               e_addr = AW'(m_wr % (1 << AW));
               e_data = m_word;
            end
         end
      end
      e_we    = nwe;
      e_done  = ndone;
      e_busy  = m_act;
      e_ready = m_act && !nwe && !ndone;
   end

   // Compare DUT outputs against the model every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_we", bus.imem_we, e_we);
         if (e_we) begin
            chk("imem_addr", bus.imem_addr, e_addr);
            chk("imem_wdata", bus.imem_wdata, e_data);
         end
         chk("byte_ready", bus.byte_ready, e_ready);
         chk("busy", busy, e_busy);
         chk("cpu_hold", cpu_hold, e_busy);
         chk("done", done, e_done);
         chk("pc_clear", pc_clear, e_done);
         chk("fmt_err", fmt_err, e_fmt);
      end
   end

   // Memory image and pulse counters seen from the DUT side.
   always @(negedge clk) begin
      if (bus.imem_we) begin
         tb_mem[bus.imem_addr] = bus.imem_wdata;
         n_wr++;
      end
      if (done) n_done++;
   end

   task automatic send(input logic [7:0] b, input bit hold);
      bit acc, r;
      acc = 0;
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         r = bus.byte_ready;
         @(posedge clk);
         #1;
         acc = r;
      end
      n_vec++;
      if (!acc) begin
         n_err++;
         $display("FAIL send_timeout: byte 0x%02h got ready=0 expected accept", b);
      end
      if (!hold) bus.byte_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = !busy;
      end
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL idle_timeout: busy got 1 expected 0");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, bus.byte_ready, 0);
      chk({tag, "_we"}, bus.imem_we, 0);
      chk({tag, "_addr"}, bus.imem_addr, 0);
      chk({tag, "_wdata"}, bus.imem_wdata, 0);
      chk({tag, "_hold"}, cpu_hold, 0);
      chk({tag, "_pcclr"}, pc_clear, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_fmt"}, fmt_err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w0, d0;
      logic [18:0] ww [18];
      logic [7:0] b;
      rst = 1'b1;
      start = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1;
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1;

      // Two-word load.
      d0 = n_done;
      do_start();
      send(8'h02, 0); send(8'h00, 0); send(8'h00, 0);
      send(8'h00, 0); send(8'h01, 0); send(8'h04, 0);
      send(8'h40, 0); send(8'h18, 0); send(8'h02, 0);
      wait_idle();
      chk("t1_mem0", tb_mem[0], 19'h40100);
      chk("t1_mem1", tb_mem[1], 19'h21840);
      chk("t1_done_cnt", n_done - d0, 1);
      chk("t1_hold", cpu_hold, 0);

      // Empty session.
      w0 = n_wr;
      do_start();
      send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
      @(negedge clk);
      chk("z_done", done, 1);
      wait_idle();
      chk("z_nowrite", n_wr, w0);

      // Valid held high, junk offered before start.
      bus.byte_in = 8'hEE;
      bus.byte_valid = 1'b1;
      do_start();
      send(8'h03, 1); send(8'h00, 1); send(8'h00, 1);
      send(8'h01, 1); send(8'h02, 1); send(8'h03, 1);
      send(8'h04, 1); send(8'h05, 1); send(8'h06, 1);
      send(8'hAA, 1); send(8'h55, 1); send(8'h05, 0);
      wait_idle();
      chk("hold_mem2", tb_mem[2], 19'h555AA);
      chk("hold_mem1", tb_mem[1], 19'h60504);

      // Bad header top byte.
      w0 = n_wr;
      do_start();
      send(8'h00, 0); send(8'h00, 0); send(8'hF8, 0);
      wait_idle();
      chk("fmt_flag", fmt_err, 1);
      chk("fmt_nowrite", n_wr, w0);

      // Reset mid-word, then a fresh session.
      w0 = n_wr;
      do_start();
      send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
      send(8'h11, 0); send(8'h22, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("midrst");
      chk("midrst_nowrite", n_wr, w0);
      @(posedge clk);
      #1;
      do_start();
      send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
      send(8'h33, 0); send(8'h44, 0); send(8'h05, 0);
      wait_idle();
      chk("midrst_mem0", tb_mem[0], 19'h54433);

      // Start pulse during DATA is ignored.
      w0 = n_wr;
      do_start();
      send(8'h02, 0); send(8'h00, 0); send(8'h00, 0);
      send(8'h01, 0);
      do_start();
      send(8'h02, 0); send(8'h03, 0);
      send(8'h04, 0); send(8'h05, 0); send(8'h06, 0);
      wait_idle();
      chk("restart_mem0", tb_mem[0], 19'h30201);
      chk("restart_mem1", tb_mem[1], 19'h60504);
      chk("restart_wcnt", n_wr - w0, 2);

      // Address wrap with 18 words into a 16-entry space.
      do_start();
      send(8'h12, 0); send(8'h00, 0); send(8'h00, 0);
      for (int i = 0; i < 18; i++) begin
         logic [7:0] b0, b1, b2;
         b0 = 8'($urandom);
         b1 = 8'($urandom);
         b2 = {5'd0, 3'($urandom)};
         ww[i] = {b2[2:0], b1, b0};
         send(b0, 1); send(b1, 1); send(b2, 0);
      end
      wait_idle();
      chk("wrap_mem0", tb_mem[0], ww[16]);
      chk("wrap_mem1", tb_mem[1], ww[17]);
      chk("wrap_mem2", tb_mem[2], ww[2]);

      // Random sessions.
      for (int s = 0; s < 14; s++) begin
         int n;
         bit hold;
         n = $urandom_range(0, 5);
         hold = 1'($urandom_range(0, 1));
         do_start();
         send(8'(n), hold);
         send(8'h00, hold);
         b = 8'h00;
         if ($urandom_range(0, 3) == 0) b = {5'($urandom), 3'd0};
         send(b, hold);
         for (int w = 0; w < 3 * n; w++) begin
            if (!hold && $urandom_range(0, 2) == 0) begin
               repeat ($urandom_range(1, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
            b = 8'($urandom);
            if (w % 3 == 2 && $urandom_range(0, 3) != 0) b[7:3] = 5'd0;
            send(b, hold && (w != 3 * n - 1));
         end
         bus.byte_valid = 1'b0;
         wait_idle();
      end

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter AW, default 19, meaning the instruction-memory address width.
REQ-002 SHALL have parameter DW, default 19, meaning the instruction word width; the framing below is fixed to 19 bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a load session; honoured only in IDLE.
REQ-006 byte_in  input  8  serial load byte.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle; transfer occurs when byte_valid and byte_ready are both high.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  AW  instruction-memory write address.
REQ-011 imem_wdata  output  DW  instruction-memory write data.
REQ-012 cpu_hold  output  1  stalls the processor PC while asserted.
REQ-013 pc_clear  output  1  one-cycle pulse forcing the processor PC to 0.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle session-complete pulse.
REQ-016 fmt_err  output  1  sticky flag: a third byte carried nonzero bits [7:3].

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, HDR, DATA, WRITE, FINISH.
REQ-018 IDLE -> HDR on start; in HDR, clear the byte counter, word address and fmt_err.
REQ-019 HDR SHALL accept 3 bytes forming word count N, little-endian: b0 = [7:0], b1 = [15:8], b2[2:0] = [18:16].
REQ-020 After the 3rd header byte: N = 0 -> FINISH; otherwise -> DATA.
REQ-021 DATA SHALL assemble each word from 3 bytes in the same little-endian layout, then -> WRITE.
REQ-022 WRITE SHALL last exactly 1 cycle: imem_we = 1, imem_addr = current address, imem_wdata = assembled word; the address then increments by 1.
REQ-023 WRITE -> FINISH when N words have been written, else -> DATA.
REQ-024 Write latency SHALL be exactly 1 cycle after the third data byte is accepted.
REQ-025 byte_ready SHALL be 1 in HDR and DATA, 0 in IDLE, WRITE and FINISH.
REQ-026 byte_valid while byte_ready = 0 SHALL be ignored: no transfer, no state change.
REQ-027 A third byte (header or data) with nonzero bits [7:3] SHALL set fmt_err; the upper bits are discarded and the load continues.
REQ-028 cpu_hold SHALL be 1 from the cycle after start is honoured through FINISH, and 0 in IDLE.
REQ-029 FINISH SHALL last 1 cycle, pulse pc_clear and done together, then -> IDLE.
REQ-030 start while busy SHALL be ignored.
REQ-031 The address SHALL wrap from 2^AW-1 to 0 with no error.
REQ-032 imem_we SHALL be 0 in every state except WRITE.

Reset
REQ-033 rst SHALL force IDLE, clear the counters, address and assembly register, and drive every output to 0, including mid-session; a partially assembled word is never written.
REQ-034 rst SHALL take priority over start and byte transfers in the same cycle.

Structure
REQ-035 The state encoding and the bytes-per-word constant (3) SHALL live in the shared processor package.
REQ-036 The sole sub-module SHALL be byte_assembler (3-byte shift/assemble register with byte counter), instantiated for both header and data.
REQ-037 The processor top SHALL connect imem_we/addr/wdata to the instruction-memory write port, and cpu_hold/pc_clear to the PC register.

Verification
REQ-038 start; header 02 00 00; data 00 01 04, 40 18 02 -> imem[0] = 0x40100, imem[1] = 0x21840; done and pc_clear pulse once; cpu_hold falls after FINISH.
REQ-039 Header 00 00 00 -> no imem_we; done asserted 1 cycle after the 3rd header byte.
REQ-040 byte_valid held high continuously -> byte_ready low in WRITE; no byte lost or duplicated; the third word lands at address 2.
REQ-041 Header third byte 0xF8 -> fmt_err = 1; N taken as 0; session completes.
REQ-042 rst asserted after 2 data bytes -> next cycle IDLE, all outputs 0, no write; a fresh session loads correctly from address 0.
REQ-043 start pulsed again during DATA -> ignored; byte stream and addresses unaffected.
